// File: rtl/vga_fb.sv
// 256x240 frame buffer of 6-bit NES colour codes. The PPU writes one port, the VGA scan reads the other,
// and each code read is turned into registered 9-bit RGB through the 2C02 palette.
module vga_fb (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic [7:0] ppu_ptr_x,
  input  logic [7:0] ppu_ptr_y,
  input  logic [5:0] ppu_DI,
  input  logic       CS,
  input  logic [7:0] pix_ptr_x,
  input  logic [7:0] pix_ptr_y,
  output logic [8:0] rgb
);

  logic [5:0]  r_mem [0:61439];
  logic [8:0]  r_rgb;
  logic [15:0] w_wr_addr;
  logic [15:0] w_rd_addr;
  logic        w_wr_en;
  logic        w_rd_valid;
  logic [5:0]  w_rd_code;

  // Quantises one 8-bit channel to 3 bits, round(v*7/255), as a threshold ladder.
  function automatic logic [2:0] q3(input logic [7:0] v);
    if      (v <= 8'h12) return 3'd0;
    else if (v <= 8'h36) return 3'd1;
    else if (v <= 8'h5B) return 3'd2;
    else if (v <= 8'h7F) return 3'd3;
    else if (v <= 8'hA3) return 3'd4;
    else if (v <= 8'hC8) return 3'd5;
    else if (v <= 8'hEC) return 3'd6;
    else                 return 3'd7;
  endfunction

  // The 24-bit table is constant, so every channel quantisation folds away into a 64-entry ROM.
  function automatic logic [8:0] palette(input logic [5:0] c);
    logic [23:0] v;
    v = 24'h000000;
    case (c)
      6'h00: v = 24'h747474;  6'h01: v = 24'h24188C;  6'h02: v = 24'h0000A8;  6'h03: v = 24'h44009C;
      6'h04: v = 24'h8C0074;  6'h05: v = 24'hA80010;  6'h06: v = 24'hA40000;  6'h07: v = 24'h7C0800;
      6'h08: v = 24'h402C00;  6'h09: v = 24'h004400;  6'h0A: v = 24'h005000;  6'h0B: v = 24'h003C14;
      6'h0C: v = 24'h183C5C;
      6'h10: v = 24'hBCBCBC;  6'h11: v = 24'h0070EC;  6'h12: v = 24'h2038EC;  6'h13: v = 24'h8000F0;
      6'h14: v = 24'hBC00BC;  6'h15: v = 24'hE40058;  6'h16: v = 24'hD82800;  6'h17: v = 24'hC84C0C;
      6'h18: v = 24'h887000;  6'h19: v = 24'h009400;  6'h1A: v = 24'h00A800;  6'h1B: v = 24'h009038;
      6'h1C: v = 24'h008088;
      6'h20: v = 24'hFCFCFC;  6'h21: v = 24'h3CBCFC;  6'h22: v = 24'h5C94FC;  6'h23: v = 24'hCC88FC;
      6'h24: v = 24'hF478FC;  6'h25: v = 24'hFC74B4;  6'h26: v = 24'hFC7460;  6'h27: v = 24'hFC9838;
      6'h28: v = 24'hF0BC3C;  6'h29: v = 24'h80D010;  6'h2A: v = 24'h4CDC48;  6'h2B: v = 24'h58F898;
      6'h2C: v = 24'h00E8D8;  6'h2D: v = 24'h787878;
      6'h30: v = 24'hFCFCFC;  6'h31: v = 24'hA8E4FC;  6'h32: v = 24'hC4D4FC;  6'h33: v = 24'hD4C8FC;
      6'h34: v = 24'hFCC4FC;  6'h35: v = 24'hFCC4D8;  6'h36: v = 24'hFCBCB0;  6'h37: v = 24'hFCD8A8;
      6'h38: v = 24'hFCE4A0;  6'h39: v = 24'hE0FCA0;  6'h3A: v = 24'hA8F0BC;  6'h3B: v = 24'hB0FCCC;
      6'h3C: v = 24'h9CFCF0;  6'h3D: v = 24'hC4C4C4;
      default: v = 24'h000000;
    endcase
    return {q3(v[23:16]), q3(v[15:8]), q3(v[7:0])};
  endfunction

  assign w_wr_addr  = {ppu_ptr_y, ppu_ptr_x};
  assign w_rd_addr  = {pix_ptr_y, pix_ptr_x};
  assign w_wr_en    = CS && (ppu_ptr_y < 8'd240);
  assign w_rd_valid = (pix_ptr_y < 8'd240);

  // Write-first: a same-edge write to the scanned pixel bypasses the stale stored code.
  always_comb begin
    w_rd_code = 6'h00;
    if (w_rd_valid) begin
      if (w_wr_en && (w_wr_addr == w_rd_addr)) w_rd_code = ppu_DI;
      else                                     w_rd_code = r_mem[w_rd_addr];
    end
  end

  // Memory has no reset so PPU writes land even while the output register is held in reset.
  always_ff @(posedge pix_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= ppu_DI;
  end

  always_ff @(posedge pix_clk) begin
    if (rst)             r_rgb <= 9'h000;
    else if (w_rd_valid) r_rgb <= palette(w_rd_code);
    else                 r_rgb <= 9'h000;
  end

  assign rgb = r_rgb;

endmodule

// File: tb/tb_vga_fb.sv
// Directed bench for vga_fb: the driver queues the expected rgb for each edge, the monitor checks it
// on the following falling edge.
module tb_vga_fb;

  logic       pix_clk;
  logic       rst;
  logic [7:0] ppu_ptr_x;
  logic [7:0] ppu_ptr_y;
  logic [5:0] ppu_DI;
  logic       CS;
  logic [7:0] pix_ptr_x;
  logic [7:0] pix_ptr_y;
  logic [8:0] rgb;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_chk;
  int         n_fail;
  logic [8:0] sweep_seen [0:5][0:11];

  // Hand-quantised 2C02 palette, written as octal R,G,B digits.
  logic [8:0] pal_tab [0:63] = '{
    9'o333, 9'o114, 9'o005, 9'o204, 9'o403, 9'o500, 9'o500, 9'o300,
    9'o210, 9'o020, 9'o020, 9'o021, 9'o123, 9'o000, 9'o000, 9'o000,
    9'o555, 9'o036, 9'o126, 9'o407, 9'o505, 9'o602, 9'o610, 9'o520,
    9'o430, 9'o040, 9'o050, 9'o042, 9'o044, 9'o000, 9'o000, 9'o000,
    9'o777, 9'o257, 9'o347, 9'o647, 9'o737, 9'o735, 9'o733, 9'o742,
    9'o752, 9'o460, 9'o262, 9'o274, 9'o066, 9'o333, 9'o000, 9'o000,
    9'o777, 9'o567, 9'o567, 9'o657, 9'o757, 9'o756, 9'o755, 9'o765,
    9'o764, 9'o674, 9'o575, 9'o576, 9'o477, 9'o555, 9'o000, 9'o000
  };

  vga_fb dut (
    .pix_clk   (pix_clk),
    .rst       (rst),
    .ppu_ptr_x (ppu_ptr_x),
    .ppu_ptr_y (ppu_ptr_y),
    .ppu_DI    (ppu_DI),
    .CS        (CS),
    .pix_ptr_x (pix_ptr_x),
    .pix_ptr_y (pix_ptr_y),
    .rgb       (rgb)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  // One edge of stimulus; when chk is set the rgb required after this edge is queued.
  task automatic cyc(input logic cs, input logic [7:0] wx, input logic [7:0] wy, input logic [5:0] di,
                     input logic [7:0] rx, input logic [7:0] ry, input logic chk,
                     input logic [8:0] exp_rgb, input string nm);
    CS        = cs;
    ppu_ptr_x = wx;
    ppu_ptr_y = wy;
    ppu_DI    = di;
    pix_ptr_x = rx;
    pix_ptr_y = ry;
    @(posedge pix_clk);
    #1;
    if (chk) begin
      exp_q.push_back(exp_rgb);
      name_q.push_back(nm);
    end
  endtask

  always @(negedge pix_clk) begin
    while (exp_q.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_chk++;
      if (rgb !== e) begin
        n_fail++;
        $display("FAIL %s: rgb=%03h expected %03h", n, rgb, e);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;

    // Reset, with a write issued during reset that must still be stored.
    cyc(1'b1, 8'd7, 8'd7, 6'h20, 8'd0, 8'd250, 1'b1, 9'h000, "reset0");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd7, 8'd7,   1'b1, 9'h000, "reset1");
    rst = 1'b0;
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd0, 8'd250, 1'b1, 9'h000, "post_reset_oob");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd7, 8'd7,   1'b1, 9'o777, "write_during_reset");

    // Write then read, and CS=0 must not write or bypass.
    cyc(1'b1, 8'd0, 8'd23, 6'h03, 8'd0, 8'd250, 1'b1, 9'h000, "wr_oob_read");
    cyc(1'b0, 8'd0, 8'd0,  6'h00, 8'd0, 8'd23,  1'b1, 9'h084, "write_then_read");
    cyc(1'b0, 8'd0, 8'd23, 6'h16, 8'd0, 8'd23,  1'b1, 9'h084, "cs0_no_write");
    cyc(1'b0, 8'd0, 8'd0,  6'h00, 8'd0, 8'd23,  1'b1, 9'h084, "cs0_persist");

    // Same-cycle write/read sweep exercises write-first on every pixel.
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 12; x++) begin
        logic [5:0] code;
        code = 6'((y + 6 * x) % 64);
        sweep_seen[y][x] = pal_tab[code];
        cyc(1'b1, 8'(x), 8'(y), code, 8'(x), 8'(y), 1'b1, pal_tab[code], "sweep");
      end
    end
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 12; x++) begin
        cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'(x), 8'(y), 1'b1, sweep_seen[y][x], "rescan");
      end
    end

    // Out-of-range rows: dropped write, black read, no aliasing onto row 224.
    cyc(1'b1, 8'd5, 8'd224, 6'h11, 8'd0, 8'd255, 1'b1, 9'h000, "oob_read_255");
    cyc(1'b1, 8'd5, 8'd240, 6'h30, 8'd5, 8'd240, 1'b1, 9'h000, "oob_same_cycle");
    cyc(1'b0, 8'd0, 8'd0,   6'h00, 8'd5, 8'd224, 1'b1, 9'o036, "no_alias_224");
    cyc(1'b1, 8'd5, 8'd250, 6'h20, 8'd5, 8'd224, 1'b1, 9'o036, "oob_write_250");
    cyc(1'b0, 8'd0, 8'd0,   6'h00, 8'd5, 8'd240, 1'b1, 9'h000, "oob_read_240");
    cyc(1'b1, 8'd255, 8'd239, 6'h16, 8'd255, 8'd239, 1'b1, 9'h188, "last_pixel");

    // Palette spot checks, then every code through row 200.
    cyc(1'b1, 8'd100, 8'd100, 6'h0F, 8'd0, 8'd250, 1'b0, 9'h000, "");
    cyc(1'b1, 8'd101, 8'd100, 6'h16, 8'd0, 8'd250, 1'b0, 9'h000, "");
    cyc(1'b1, 8'd102, 8'd100, 6'h20, 8'd0, 8'd250, 1'b0, 9'h000, "");
    cyc(1'b1, 8'd103, 8'd100, 6'h30, 8'd0, 8'd250, 1'b0, 9'h000, "");
    cyc(1'b1, 8'd104, 8'd100, 6'h3F, 8'd0, 8'd250, 1'b0, 9'h000, "");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd100, 8'd100, 1'b1, 9'h000, "pal_0F");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd101, 8'd100, 1'b1, 9'h188, "pal_16");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd102, 8'd100, 1'b1, 9'h1FF, "pal_20");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd103, 8'd100, 1'b1, 9'h1FF, "pal_30");
    cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'd104, 8'd100, 1'b1, 9'h000, "pal_3F");
    for (int c = 0; c < 64; c++) begin
      cyc(1'b1, 8'(c), 8'd200, 6'(c), 8'd0, 8'd250, 1'b0, 9'h000, "");
    end
    for (int c = 0; c < 64; c++) begin
      cyc(1'b0, 8'd0, 8'd0, 6'h00, 8'(c), 8'd200, 1'b1, pal_tab[c], "pal_all");
    end

    @(negedge pix_clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
